// File: rtl/jpeg2000_cs_pkg.sv
// Shared JPEG2000 codestream marker bytes and the boundary-tracker state type.
package jpeg2000_cs_pkg;

    localparam logic [7:0] MRK_PREFIX = 8'hFF;
    localparam logic [7:0] MRK_SOC    = 8'h4F;
    localparam logic [7:0] MRK_EOC    = 8'hD9;

    typedef enum logic {
        IDLE  = 1'b0,
        IN_CS = 1'b1
    } cs_state_t;

endpackage

// File: rtl/cs_word_fifo.sv
// Word FIFO with a combinational read port so a popped entry is usable in the same
// cycle; o_level is the registered occupancy.
module cs_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/codestream_sink.sv
// Consumes byte-enabled word writes, emits them as a big-endian byte stream and
// measures each SOC..EOC codestream; flags address gaps and dropped writes.
module codestream_sink
    import jpeg2000_cs_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_CHECK = 1
) (
    input  logic                          clk_dwt,
    input  logic                          rst,
    input  logic [3:0]                    write_en,
    input  logic [31:0]                   output_address,
    input  logic [31:0]                   output_to_fpga_32,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          byte_soc,
    output logic                          byte_eoc,
    output logic                          cs_done,
    output logic [31:0]                   cs_len,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          addr_err,
    output logic                          ovf,
    input  logic                          clear_err
);
    logic        w_wr, w_push, w_pop, w_drop, w_full, w_empty;
    logic [35:0] w_fifo_rdata;
    logic [1:0]  w_lane_idx;
    logic [3:0]  w_lane_rem;
    logic        w_hs, w_is_soc, w_is_eoc, w_cs_end, w_addr_mis;

    logic [3:0]  r_lanes;
    logic [31:0] r_data;
    logic        r_prev_ff;
    cs_state_t   r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_cs_len;
    logic        r_cs_done;
    logic        r_have_prev;
    logic [31:0] r_prev_addr;
    logic        r_addr_err;
    logic        r_ovf;

    assign w_wr   = |write_en;
    assign w_push = w_wr && (!w_full || w_pop);
    assign w_drop = w_wr && w_full && !w_pop;

    cs_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk     (clk_dwt),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_wdata ({write_en, output_to_fpga_32}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // r_lanes holds the lanes still to be sent; the highest one is on the bus.
    always_comb begin
        w_lane_idx = 2'd0;
        if (r_lanes[3]) begin
            w_lane_idx = 2'd3;
        end else if (r_lanes[2]) begin
            w_lane_idx = 2'd2;
        end else if (r_lanes[1]) begin
            w_lane_idx = 2'd1;
        end
    end

    assign w_lane_rem = r_lanes & ~(4'b0001 << w_lane_idx);
    assign byte_valid = |r_lanes;
    assign byte_data  = byte_valid ? r_data[{w_lane_idx, 3'b000} +: 8] : 8'h00;
    assign w_hs       = byte_valid && byte_ready;
    assign w_pop      = (!byte_valid || (w_hs && (w_lane_rem == 4'd0))) && !w_empty;
    assign w_is_soc   = byte_valid && r_prev_ff && (byte_data == MRK_SOC);
    assign w_is_eoc   = byte_valid && r_prev_ff && (byte_data == MRK_EOC);
    assign w_cs_end   = w_hs && w_is_eoc && !w_is_soc && (r_state == IN_CS);
    assign byte_soc   = w_is_soc;
    assign byte_eoc   = w_is_eoc;
    assign cs_done    = r_cs_done;
    assign cs_len     = r_cs_len;
    assign addr_err   = r_addr_err;
    assign ovf        = r_ovf;

    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            r_lanes <= 4'd0;
            r_data  <= 32'd0;
        end else if (w_pop) begin
            r_lanes <= w_fifo_rdata[35:32];
            r_data  <= w_fifo_rdata[31:0];
        end else if (w_hs) begin
            r_lanes <= w_lane_rem;
        end
    end

    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            r_prev_ff <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= 32'd0;
            r_cs_len  <= 32'd0;
            r_cs_done <= 1'b0;
        end else begin
            r_cs_done <= 1'b0;
            if (w_hs) begin
                r_prev_ff <= (byte_data == MRK_PREFIX);
                // A SOC always (re)starts the count, even inside a codestream.
                if (w_is_soc) begin
                    r_state <= IN_CS;
                    r_cnt   <= 32'd2;
                end else if (w_cs_end) begin
                    r_state   <= IDLE;
                    r_cs_len  <= r_cnt + 32'd1;
                    r_cs_done <= 1'b1;
                end else if (r_state == IN_CS) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign w_addr_mis = (ADDR_CHECK != 0) && w_wr && r_have_prev
                        && (output_address != r_prev_addr + 32'd1);

    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            r_have_prev <= 1'b0;
            r_prev_addr <= 32'd0;
            r_addr_err  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_cs_end) begin
                r_have_prev <= 1'b0;
            end
            if (w_wr) begin
                r_have_prev <= 1'b1;
                r_prev_addr <= output_address;
            end
            r_addr_err <= (r_addr_err && !clear_err) || w_addr_mis;
            r_ovf      <= (r_ovf && !clear_err) || w_drop;
        end
    end

endmodule

// File: tb/tb_codestream_sink.sv
// Directed bench for codestream_sink: marker tracking, lane skipping, address and
// overflow flags, a 1 kB stalled stream and mid-stream reset.
module tb_codestream_sink;
    localparam int DEPTH = 16;

    logic        clk_dwt = 1'b0;
    logic        rst;
    logic [3:0]  write_en;
    logic [31:0] output_address;
    logic [31:0] output_to_fpga_32;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_soc;
    logic        byte_eoc;
    logic        cs_done;
    logic [31:0] cs_len;
    logic [4:0]  fifo_level;
    logic        addr_err;
    logic        ovf;
    logic        clear_err;

    int          total = 0;
    int          bad = 0;
    logic [9:0]  cap_q[$];
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_beat = 10'd0;

    codestream_sink #(.FIFO_DEPTH(DEPTH), .ADDR_CHECK(1)) dut (
        .clk_dwt           (clk_dwt),
        .rst               (rst),
        .write_en          (write_en),
        .output_address    (output_address),
        .output_to_fpga_32 (output_to_fpga_32),
        .byte_data         (byte_data),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .byte_soc          (byte_soc),
        .byte_eoc          (byte_eoc),
        .cs_done           (cs_done),
        .cs_len            (cs_len),
        .fifo_level        (fifo_level),
        .addr_err          (addr_err),
        .ovf               (ovf),
        .clear_err         (clear_err)
    );

    always #5 clk_dwt = ~clk_dwt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshakes are captured on the falling edge; inputs only change just after rising edges.
    always @(negedge clk_dwt) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, byte_valid}, 32'd1);
                chk("stall_beat", {22'd0, byte_soc, byte_eoc, byte_data}, {22'd0, prev_beat});
            end
            if (byte_valid && byte_ready) cap_q.push_back({byte_soc, byte_eoc, byte_data});
            if (cs_done) done_cnt++;
            prev_stall = byte_valid && !byte_ready;
            prev_beat  = {byte_soc, byte_eoc, byte_data};
        end
    end

    task automatic tick();
        @(posedge clk_dwt);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        write_en = e;
        output_address = a;
        output_to_fpga_32 = d;
        $display("wr addr=%h en=%b data=%h", a, e, d);
        tick();
        write_en = 4'h0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, cap_q.size(), n);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
        chk({tag, "_soc"},   {31'd0, byte_soc},   32'd0);
        chk({tag, "_eoc"},   {31'd0, byte_eoc},   32'd0);
        chk({tag, "_done"},  {31'd0, cs_done},    32'd0);
        chk({tag, "_aerr"},  {31'd0, addr_err},   32'd0);
        chk({tag, "_ovf"},   {31'd0, ovf},        32'd0);
        chk({tag, "_data"},  {24'd0, byte_data},  32'd0);
        chk({tag, "_len"},   cs_len,              32'd0);
        chk({tag, "_level"}, {27'd0, fifo_level}, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        cap_q.delete();
    endtask

    initial begin
        int         k, cyc, errs, done0;
        logic [9:0] t1_exp [6];
        logic [9:0] eb;
        logic [7:0] exp_b [1024];
        logic [31:0] words [256];

        rst = 1'b0; write_en = 4'h0; output_address = 32'd0; output_to_fpga_32 = 32'd0;
        byte_ready = 1'b1; clear_err = 1'b0;
        tick(); tick();
        check_reset_vals("rst0");
        rst = 1'b1;
        tick();

        // Minimal codestream FF4F 0000 FFD9 with first-byte latency checks
        write_en = 4'b1111; output_address = 32'd0; output_to_fpga_32 = 32'hFF4F0000;
        tick();
        chk("lat_n1_valid", {31'd0, byte_valid}, 32'd0);
        chk("lat_n1_level", {27'd0, fifo_level}, 32'd1);
        write_en = 4'b1100; output_address = 32'd1; output_to_fpga_32 = 32'hFFD90000;
        tick();
        write_en = 4'h0;
        chk("lat_n2_valid", {31'd0, byte_valid}, 32'd1);
        chk("lat_n2_data", {24'd0, byte_data}, 32'h0000_00FF);
        wait_bytes(6, 30, "t1_count");
        t1_exp = '{10'h0FF, 10'h24F, 10'h000, 10'h000, 10'h0FF, 10'h1D9};
        for (int i = 0; i < 6; i++) chk($sformatf("t1_byte%0d", i), {22'd0, cap_q[i]}, {22'd0, t1_exp[i]});
        wait_done(1, 20, "t1_done");
        chk("t1_len", cs_len, 32'd6);
        chk("t1_pulse_end", {31'd0, cs_done}, 32'd0);
        chk("t1_no_aerr", {31'd0, addr_err}, 32'd0);

        // Sparse lanes and an all-zero enable
        cap_q.delete();
        do_write(32'h10, 32'hAABBCCDD, 4'b1010);
        do_write(32'h99, 32'h12345678, 4'b0000);
        repeat (8) tick();
        chk("t2_count", cap_q.size(), 32'd2);
        chk("t2_b0", {22'd0, cap_q[0]}, 32'h0AA);
        chk("t2_b1", {22'd0, cap_q[1]}, 32'h0CC);
        chk("t2_no_aerr", {31'd0, addr_err}, 32'd0);

        // Address discontinuity 5,6,8 and clear/set priority
        apply_reset();
        do_write(32'd5, 32'h01020304, 4'hF);
        do_write(32'd6, 32'h05060708, 4'hF);
        chk("t3_aerr_ok", {31'd0, addr_err}, 32'd0);
        do_write(32'd8, 32'h090A0B0C, 4'hF);
        chk("t3_aerr_set", {31'd0, addr_err}, 32'd1);
        wait_bytes(12, 40, "t3_count");
        errs = 0;
        for (int i = 0; i < 12; i++) if (cap_q[i] !== 10'(i + 1)) errs++;
        chk("t3_bytes", errs, 32'd0);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("t3_aerr_clr", {31'd0, addr_err}, 32'd0);
        clear_err = 1'b1;
        do_write(32'h20, 32'h11111111, 4'hF);
        clear_err = 1'b0;
        chk("t3_clr_vs_set", {31'd0, addr_err}, 32'd1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("t3_aerr_clr2", {31'd0, addr_err}, 32'd0);
        wait_bytes(16, 40, "t3_count2");

        // Overflow with the sink stalled
        apply_reset();
        byte_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) do_write(32'(i), 32'h01010101 * 32'(i), 4'hF);
        chk("t4_level_full", {27'd0, fifo_level}, 32'(DEPTH));
        chk("t4_ovf_clear", {31'd0, ovf}, 32'd0);
        do_write(32'(DEPTH + 1), 32'hEEEEEEEE, 4'hF);
        chk("t4_level", {27'd0, fifo_level}, 32'(DEPTH));
        chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
        byte_ready = 1'b1;
        wait_bytes(4 * (DEPTH + 1), 300, "t4_drain_min");
        repeat (10) tick();
        chk("t4_drain_exact", cap_q.size(), 32'(4 * (DEPTH + 1)));
        chk("t4_last_byte", {22'd0, cap_q[4 * DEPTH + 3]}, 32'(DEPTH));
        chk("t4_level_empty", {27'd0, fifo_level}, 32'd0);
        chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);

        // 1 kB codestream with random back-pressure
        apply_reset();
        done0 = done_cnt;
        exp_b[0] = 8'hFF; exp_b[1] = 8'h4F; exp_b[1022] = 8'hFF; exp_b[1023] = 8'hD9;
        for (int i = 2; i < 1022; i++) exp_b[i] = 8'($urandom_range(0, 254));
        for (int w = 0; w < 256; w++) words[w] = {exp_b[4*w], exp_b[4*w+1], exp_b[4*w+2], exp_b[4*w+3]};
        k = 0; cyc = 0;
        while ((k < 256 || cap_q.size() < 1024) && cyc < 20000) begin
            byte_ready = 1'($urandom_range(0, 1));
            if (k < 256 && fifo_level < 5'd12) begin
                write_en = 4'hF; output_address = 32'(k); output_to_fpga_32 = words[k];
                k++;
            end else begin
                write_en = 4'h0;
            end
            tick();
            cyc++;
        end
        write_en = 4'h0; byte_ready = 1'b1;
        wait_done(done0 + 1, 20, "t5_done");
        chk("t5_count", cap_q.size(), 32'd1024);
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            eb = {(i == 1), (i == 1023), exp_b[i]};
            if (cap_q[i] !== eb) errs++;
        end
        chk("t5_bytes", errs, 32'd0);
        chk("t5_len", cs_len, 32'd1024);
        chk("t5_ovf", {31'd0, ovf}, 32'd0);
        chk("t5_aerr", {31'd0, addr_err}, 32'd0);

        // Reset in the middle of a codestream, then a clean one
        apply_reset();
        do_write(32'd0, 32'hFF4F0102, 4'hF);
        do_write(32'd1, 32'h03040506, 4'hF);
        tick();
        byte_ready = 1'b0;
        do_write(32'd2, 32'h0708090A, 4'hF);
        tick();
        rst = 1'b0;
        #1;
        check_reset_vals("mid");
        tick();
        rst = 1'b1;
        tick();
        cap_q.delete();
        byte_ready = 1'b1;
        done0 = done_cnt;
        do_write(32'd0, 32'hFF4F0A0B, 4'hF);
        do_write(32'd1, 32'h0C0DFFD9, 4'hF);
        wait_done(done0 + 1, 30, "t6_done");
        chk("t6_count", cap_q.size(), 32'd8);
        chk("t6_len", cs_len, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
